// File: rtl/neighbor_scan.sv
// Neighbor-table read engine: walks entries 0..N-1 one per cycle and keeps the
// best qualifying next hop (highest Q, then fewest hops, then lowest index).
module neighbor_scan #(
  parameter int WORD_WIDTH  = 16,
  parameter int TABLE_DEPTH = 32,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  HB_Reset,
  input  logic [IDX_WIDTH:0]    neighborTotal,
  input  logic [WORD_WIDTH-1:0] energyThreshold,
  output logic [IDX_WIDTH-1:0]  rdIndex,
  input  logic [WORD_WIDTH-1:0] mNodeID,
  input  logic [WORD_WIDTH-1:0] mNodeHops,
  input  logic [WORD_WIDTH-1:0] mNodeQValue,
  input  logic [WORD_WIDTH-1:0] mNodeEnergy,
  input  logic                  mValid,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [WORD_WIDTH-1:0] bestNodeID,
  output logic [WORD_WIDTH-1:0] bestQValue,
  output logic [WORD_WIDTH-1:0] bestHops,
  output logic [IDX_WIDTH-1:0]  bestIndex
);

  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_scan = 2'd1;
  localparam logic [1:0] s_done = 2'd2;

  localparam logic [IDX_WIDTH:0] DEPTH = (IDX_WIDTH+1)'(TABLE_DEPTH);

  logic [1:0]            state;
  logic [IDX_WIDTH:0]    n_q;
  logic [WORD_WIDTH-1:0] thr_q;
  logic [IDX_WIDTH:0]    n_clamp;
  logic                  qual, better, last;

  always_comb begin
    n_clamp = (neighborTotal > DEPTH) ? DEPTH : neighborTotal;
    qual    = mValid && (mNodeEnergy >= thr_q);
    // Full ties keep the incumbent, so the earliest index wins.
    better  = !found || (mNodeQValue > bestQValue) ||
              ((mNodeQValue == bestQValue) && (mNodeHops < bestHops));
    last    = ({1'b0, rdIndex} == (n_q - (IDX_WIDTH+1)'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= s_idle;
      rdIndex    <= '0;
      n_q        <= '0;
      thr_q      <= '0;
      found      <= 1'b0;
      bestNodeID <= '0;
      bestQValue <= '0;
      bestHops   <= '0;
      bestIndex  <= '0;
    end else if (HB_Reset) begin
      // Heartbeat abort keeps the latched N/threshold.
      state      <= s_idle;
      rdIndex    <= '0;
      found      <= 1'b0;
      bestNodeID <= '0;
      bestQValue <= '0;
      bestHops   <= '0;
      bestIndex  <= '0;
    end else begin
      case (state)
        s_idle: if (start) begin
          found      <= 1'b0;
          bestNodeID <= '0;
          bestQValue <= '0;
          bestHops   <= '0;
          bestIndex  <= '0;
          rdIndex    <= '0;
          n_q        <= n_clamp;
          thr_q      <= energyThreshold;
          state      <= (n_clamp == '0) ? s_done : s_scan;
        end
        s_scan: begin
          if (qual && better) begin
            found      <= 1'b1;
            bestNodeID <= mNodeID;
            bestQValue <= mNodeQValue;
            bestHops   <= mNodeHops;
            bestIndex  <= rdIndex;
          end
          if (last) begin
            state   <= s_done;
            rdIndex <= '0;
          end else begin
            rdIndex <= rdIndex + 1'b1;
          end
        end
        s_done:  state <= s_idle;
        default: state <= s_idle;
      endcase
    end
  end

  assign busy = (state == s_scan) || (state == s_done);
  assign done = (state == s_done) && !HB_Reset;

endmodule

// File: tb/tb_neighbor_scan.sv
// Directed + randomized bench for neighbor_scan against a priority-filter model.
module tb_neighbor_scan;

  logic        clk = 1'b0;
  logic        rst, start, HB_Reset, mValid;
  logic [5:0]  neighborTotal;
  logic [15:0] energyThreshold;
  logic [4:0]  rdIndex, bestIndex;
  logic [15:0] mNodeID, mNodeHops, mNodeQValue, mNodeEnergy;
  logic        busy, done, found;
  logic [15:0] bestNodeID, bestQValue, bestHops;

  logic [15:0] t_id[32], t_q[32], t_h[32], t_e[32];
  logic        t_v[32];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  neighbor_scan dut (
    .clk(clk), .rst(rst), .start(start), .HB_Reset(HB_Reset),
    .neighborTotal(neighborTotal), .energyThreshold(energyThreshold),
    .rdIndex(rdIndex), .mNodeID(mNodeID), .mNodeHops(mNodeHops),
    .mNodeQValue(mNodeQValue), .mNodeEnergy(mNodeEnergy), .mValid(mValid),
    .busy(busy), .done(done), .found(found), .bestNodeID(bestNodeID),
    .bestQValue(bestQValue), .bestHops(bestHops), .bestIndex(bestIndex)
  );

  // Zero-latency table read port
  always_comb begin
    mNodeID     = t_id[rdIndex];
    mNodeQValue = t_q[rdIndex];
    mNodeHops   = t_h[rdIndex];
    mNodeEnergy = t_e[rdIndex];
    mValid      = t_v[rdIndex];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_entry(input int i, input int q, input int h, input bit v, input int e);
    t_id[i] = 16'(16'h100 + i);
    t_q[i]  = 16'(q);
    t_h[i]  = 16'(h);
    t_v[i]  = v;
    t_e[i]  = 16'(e);
  endtask

  // Filter the qualifying set, take max Q, then min hops, then lowest index.
  task automatic model(input int nc, input logic [15:0] thr, output bit ef, output int ei);
    int maxq, minh;
    ef = 0; ei = 0; maxq = -1; minh = 1 << 20;
    for (int i = 0; i < nc; i++)
      if (t_v[i] && t_e[i] >= thr && int'(t_q[i]) > maxq) maxq = int'(t_q[i]);
    for (int i = 0; i < nc; i++)
      if (t_v[i] && t_e[i] >= thr && int'(t_q[i]) == maxq && int'(t_h[i]) < minh) minh = int'(t_h[i]);
    for (int i = nc - 1; i >= 0; i--)
      if (t_v[i] && t_e[i] >= thr && int'(t_q[i]) == maxq && int'(t_h[i]) == minh) begin
        ef = 1; ei = i;
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " found"}, found, 0);
    chk({tag, " rdIndex"}, rdIndex, 0);
    chk({tag, " bestNodeID"}, bestNodeID, 0);
    chk({tag, " bestQValue"}, bestQValue, 0);
    chk({tag, " bestHops"}, bestHops, 0);
    chk({tag, " bestIndex"}, bestIndex, 0);
  endtask

  task automatic run_scan(input int n, input logic [15:0] thr, input bit midstart, input string tag);
    int nc, lat, ei;
    bit ef;
    nc = (n > 32) ? 32 : n;
    model(nc, thr, ef, ei);
    @(negedge clk);
    start = 1'b1; neighborTotal = 6'(n); energyThreshold = thr;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 100; c++) begin
      if (done) begin lat = c; break; end
      if (c <= nc) chk({tag, " rdIndex"}, rdIndex, 32'(c - 1));
      if (midstart && c == 5) begin
        start = 1'b1; neighborTotal = 6'd3; energyThreshold = 16'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(nc + 1));
    chk({tag, " busy@done"}, busy, 1);
    chk({tag, " found"}, found, 32'(ef));
    chk({tag, " bestIndex"}, bestIndex, ef ? 32'(ei) : 0);
    chk({tag, " bestNodeID"}, bestNodeID, ef ? 32'(t_id[ei]) : 0);
    chk({tag, " bestQValue"}, bestQValue, ef ? 32'(t_q[ei]) : 0);
    chk({tag, " bestHops"}, bestHops, ef ? 32'(t_h[ei]) : 0);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy after"}, busy, 0);
    chk({tag, " found hold"}, found, 32'(ef));
    chk({tag, " rdIndex idle"}, rdIndex, 0);
  endtask

  task automatic rand_table();
    for (int i = 0; i < 32; i++)
      set_entry(i, $urandom_range(0, 3), $urandom_range(0, 3), ($urandom % 4) != 0, $urandom_range(0, 200));
  endtask

  initial begin
    int guard, dones;
    rst = 1'b1; start = 1'b0; HB_Reset = 1'b0;
    neighborTotal = '0; energyThreshold = '0;
    for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Basic selection
    set_entry(0, 10, 3, 1, 100);
    set_entry(1, 40, 2, 1, 100);
    set_entry(2, 40, 1, 1, 100);
    set_entry(3, 50, 1, 0, 100);
    run_scan(4, 16'd50, 0, "basic");

    // Energy filter and full tie
    set_entry(0, 30, 2, 1, 60);
    set_entry(1, 30, 2, 1, 60);
    set_entry(2, 90, 2, 1, 10);
    run_scan(3, 16'd50, 0, "tie");

    run_scan(0, 16'd0, 0, "n0");
    for (int i = 0; i < 3; i++) t_v[i] = 1'b0;
    run_scan(3, 16'd0, 0, "invalid");

    // Heartbeat abort at rdIndex 10
    rand_table();
    t_v[5] = 1'b1; t_e[5] = 16'd10;
    @(negedge clk); start = 1'b1; neighborTotal = 6'd32; energyThreshold = 16'd0;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (rdIndex != 5'd10 && guard < 40) begin @(negedge clk); guard++; end
    chk("abort reach idx10", rdIndex, 10);
    HB_Reset = 1'b1;
    @(negedge clk); HB_Reset = 1'b0;
    chk_reset_vals("abort");
    dones = 0;
    repeat (40) begin @(negedge clk); if (done) dones++; end
    chk("abort no done", 32'(dones), 0);
    run_scan(32, 16'd0, 0, "restart");

    // Clamp with an ignored mid-scan start
    rand_table();
    run_scan(40, 16'd50, 1, "clamp");

    // Synchronous reset mid-scan
    rand_table();
    t_v[0] = 1'b1; t_e[0] = 16'd100;
    @(negedge clk); start = 1'b1; neighborTotal = 6'd20; energyThreshold = 16'd0;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (rdIndex != 5'd5 && guard < 40) begin @(negedge clk); guard++; end
    rst = 1'b1;
    #1;
    chk("rst pre-edge busy", busy, 1);
    chk("rst pre-edge rdIndex", rdIndex, 5);
    chk("rst pre-edge found", found, 1);
    @(negedge clk);
    chk_reset_vals("syncrst");
    rst = 1'b0;

    for (int r = 0; r < 25; r++) begin
      rand_table();
      run_scan($urandom_range(0, 40), 16'($urandom_range(0, 200)), 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
